// File: rtl/soc_pm_pkg.sv
// Shared definitions for the program-memory data path: bus widths and the
// wide-adapter sequencing states.
package soc_pm_pkg;

  localparam int PM_DATA_W = 64;
  localparam int PM_HALF_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_CAP,
    WR_LO,
    WR_HI
  } pm_adapter_state_t;

endpackage

// File: rtl/soc_pm_data.sv
// 64-bit program-memory data bundle. It carries no handshake; sequencing is
// done by side-band request/busy/valid signals.
interface soc_pm_data;
  import soc_pm_pkg::*;

  logic [PM_DATA_W-1:0] dout;
  logic [PM_DATA_W-1:0] din;

  modport slave  (output dout, input din);
  modport master (input dout, output din);

endinterface

// File: rtl/soc_pm_wide_adapter.sv
// Maps each 64-bit program-memory access onto two 32-bit beats of a
// single-port SRAM. Every output comes straight from a register.
module soc_pm_wide_adapter
  import soc_pm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  soc_pm_data.slave            pm_data,
  input  logic                 pm_req,
  input  logic                 pm_we,
  input  logic [ADDR_W-1:0]    pm_addr,
  output logic                 pm_busy,
  output logic                 pm_rvalid,
  output logic                 pm_wdone,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W:0]      mem_addr,
  output logic [PM_HALF_W-1:0] mem_wdata,
  input  logic [PM_HALF_W-1:0] mem_rdata
);

  pm_adapter_state_t    r_state, w_state_next;
  logic                 r_busy, r_rvalid, r_wdone, r_mem_en, r_mem_we;
  logic                 w_rvalid_next, w_wdone_next, w_mem_en_next, w_mem_we_next;
  logic [PM_DATA_W-1:0] r_dout, w_dout_next;
  logic [ADDR_W-1:0]    r_addr, w_addr_next;
  logic [PM_HALF_W-1:0] r_din_hi, w_din_hi_next;
  logic [PM_HALF_W-1:0] r_lo, w_lo_next;
  logic [ADDR_W:0]      r_mem_addr, w_mem_addr_next;
  logic [PM_HALF_W-1:0] r_mem_wdata, w_mem_wdata_next;

  // Memory-side controls are computed for the state being entered, so the
  // SRAM beat is presented from registers in that state's cycle.
  always_comb begin
    w_state_next     = r_state;
    w_rvalid_next    = 1'b0;
    w_wdone_next     = 1'b0;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = 1'b0;
    w_dout_next      = r_dout;
    w_addr_next      = r_addr;
    w_din_hi_next    = r_din_hi;
    w_lo_next        = r_lo;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (pm_req) begin
          w_addr_next      = pm_addr;
          w_mem_en_next    = 1'b1;
          w_mem_we_next    = pm_we;
          w_mem_addr_next  = {pm_addr, 1'b0};
          w_mem_wdata_next = pm_data.din[PM_HALF_W-1:0];
          if (pm_we) begin
            w_din_hi_next = pm_data.din[PM_DATA_W-1:PM_HALF_W];
            w_state_next  = WR_LO;
          end else begin
            w_state_next  = RD_LO;
          end
        end
      end
      RD_LO: begin
        w_mem_en_next   = 1'b1;
        w_mem_addr_next = {r_addr, 1'b1};
        w_state_next    = RD_HI;
      end
      RD_HI: begin
        w_lo_next    = mem_rdata;
        w_state_next = RD_CAP;
      end
      RD_CAP: begin
        w_dout_next   = {mem_rdata, r_lo};
        w_rvalid_next = 1'b1;
        w_state_next  = IDLE;
      end
      WR_LO: begin
        w_mem_en_next    = 1'b1;
        w_mem_we_next    = 1'b1;
        w_mem_addr_next  = {r_addr, 1'b1};
        w_mem_wdata_next = r_din_hi;
        w_state_next     = WR_HI;
      end
      WR_HI: begin
        w_wdone_next = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_busy   <= (w_state_next != IDLE);
      r_rvalid <= w_rvalid_next;
      r_wdone  <= w_wdone_next;
      r_mem_en <= w_mem_en_next;
      r_mem_we <= w_mem_we_next;
      r_dout   <= w_dout_next;
    end
  end

  // Datapath holding registers need no reset: they are only observed when
  // qualified by a control register above.
  always_ff @(posedge clk) begin
    r_addr      <= w_addr_next;
    r_din_hi    <= w_din_hi_next;
    r_lo        <= w_lo_next;
    r_mem_addr  <= w_mem_addr_next;
    r_mem_wdata <= w_mem_wdata_next;
  end

  assign pm_data.dout = r_dout;
  assign pm_busy      = r_busy;
  assign pm_rvalid    = r_rvalid;
  assign pm_wdone     = r_wdone;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_soc_pm_wide_adapter.sv
// Bench for soc_pm_wide_adapter: SRAM model plus a 64-bit word-level
// reference memory, directed cases followed by randomized back-to-back traffic.
module tb_soc_pm_wide_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pm_req, pm_we;
  logic [11:0] pm_addr;
  logic        pm_busy, pm_rvalid, pm_wdone, mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  soc_pm_data pm_if ();

  soc_pm_wide_adapter #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pm_data   (pm_if),
    .pm_req    (pm_req),
    .pm_we     (pm_we),
    .pm_addr   (pm_addr),
    .pm_busy   (pm_busy),
    .pm_rvalid (pm_rvalid),
    .pm_wdone  (pm_wdone),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [0:8191];
  logic [63:0] ref_mem [0:4095];
  logic [63:0] exp_dout;
  int          n_vec = 0;
  int          n_err = 0;

  // Single-port SRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access from accept cycle T to the cycle where a new accept is
  // legal; poke drives spurious requests while busy.
  task automatic access(input bit we, input logic [11:0] a, input logic [63:0] d, input bit poke);
    logic [12:0] lo_a, hi_a;
    lo_a = {a, 1'b0};
    hi_a = {a, 1'b1};
    chk("accept_busy", 64'(pm_busy), 64'd0);
    pm_req = 1'b1; pm_we = we; pm_addr = a; pm_if.din = d;
    step();
    pm_req = poke; pm_we = ~we; pm_addr = a ^ 12'h5; pm_if.din = {$urandom, $urandom};
    chk("t1_en",   64'(mem_en),   64'd1);
    chk("t1_we",   64'(mem_we),   64'(we));
    chk("t1_addr", 64'(mem_addr), 64'(lo_a));
    chk("t1_busy", 64'(pm_busy),  64'd1);
    if (we) chk("t1_wdata", 64'(mem_wdata), 64'(d[31:0]));
    step();
    chk("t2_en",   64'(mem_en),   64'd1);
    chk("t2_we",   64'(mem_we),   64'(we));
    chk("t2_addr", 64'(mem_addr), 64'(hi_a));
    chk("t2_busy", 64'(pm_busy),  64'd1);
    chk("t2_dout", pm_if.dout,    exp_dout);
    if (we) chk("t2_wdata", 64'(mem_wdata), 64'(d[63:32]));
    step();
    if (we) begin
      ref_mem[a] = d;
      chk("wr_done",   64'(pm_wdone),  64'd1);
      chk("wr_busy",   64'(pm_busy),   64'd0);
      chk("wr_en",     64'(mem_en),    64'd0);
      chk("wr_rvalid", 64'(pm_rvalid), 64'd0);
      chk("wr_dout",   pm_if.dout,     exp_dout);
      $display("write addr=%h data=%h", a, d);
    end else begin
      chk("t3_en",     64'(mem_en),    64'd0);
      chk("t3_busy",   64'(pm_busy),   64'd1);
      chk("t3_rvalid", 64'(pm_rvalid), 64'd0);
      step();
      exp_dout = ref_mem[a];
      chk("rd_valid", 64'(pm_rvalid), 64'd1);
      chk("rd_busy",  64'(pm_busy),   64'd0);
      chk("rd_wdone", 64'(pm_wdone),  64'd0);
      chk("rd_en",    64'(mem_en),    64'd0);
      chk("rd_dout",  pm_if.dout,     exp_dout);
      $display("read  addr=%h data=%h", a, pm_if.dout);
    end
    pm_req = 1'b0;
  endtask

  initial begin
    logic [31:0] w_lo, w_hi;
    bit          we, poke;
    logic [11:0] a;
    logic [63:0] d;

    rst_n = 1'b0; pm_req = 1'b0; pm_we = 1'b0; pm_addr = '0;
    pm_if.din = '0; exp_dout = '0;
    for (int i = 0; i < 4096; i++) begin
      w_lo = $urandom; w_hi = $urandom;
      sram[13'(2*i)] = w_lo; sram[13'(2*i+1)] = w_hi;
      ref_mem[i] = {w_hi, w_lo};
    end
    sram[13'h010] = 32'h89ABCDEF;
    sram[13'h011] = 32'h01234567;
    ref_mem[12'h008] = 64'h0123456789ABCDEF;

    repeat (3) step();
    chk("rst_busy",   64'(pm_busy),   64'd0);
    chk("rst_rvalid", 64'(pm_rvalid), 64'd0);
    chk("rst_wdone",  64'(pm_wdone),  64'd0);
    chk("rst_en",     64'(mem_en),    64'd0);
    chk("rst_we",     64'(mem_we),    64'd0);
    chk("rst_dout",   pm_if.dout,     64'd0);
    rst_n = 1'b1;
    step();

    access(1'b0, 12'h008, 64'd0, 1'b0);
    chk("tp_read", pm_if.dout, 64'h0123456789ABCDEF);
    access(1'b1, 12'h003, 64'hDEADBEEFCAFEF00D, 1'b0);
    chk("tp_sram_lo", 64'(sram[13'h006]), 64'h00000000CAFEF00D);
    chk("tp_sram_hi", 64'(sram[13'h007]), 64'h00000000DEADBEEF);
    access(1'b0, 12'h003, 64'd0, 1'b0);
    chk("tp_wr_rd", pm_if.dout, 64'hDEADBEEFCAFEF00D);

    // Requests while busy are dropped; the re-request in the rvalid cycle goes through.
    access(1'b0, 12'h008, 64'd0, 1'b1);
    access(1'b1, 12'h008, 64'h1122334455667788, 1'b1);
    access(1'b0, 12'h008, 64'd0, 1'b0);

    // Reset two cycles into a read.
    pm_req = 1'b1; pm_we = 1'b0; pm_addr = 12'h005;
    step();
    pm_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("abort_dout",   pm_if.dout,     64'd0);
    chk("abort_busy",   64'(pm_busy),   64'd0);
    chk("abort_en",     64'(mem_en),    64'd0);
    chk("abort_rvalid", 64'(pm_rvalid), 64'd0);
    rst_n = 1'b1;
    exp_dout = '0;
    step();
    chk("abort_rvalid2", 64'(pm_rvalid), 64'd0);
    chk("abort_busy2",   64'(pm_busy),   64'd0);

    for (int n = 0; n < 100; n++) begin
      we   = 1'($urandom_range(0, 1));
      poke = 1'($urandom_range(0, 1));
      a    = 12'($urandom_range(0, 31));
      d    = {$urandom, $urandom};
      access(we, a, d, poke);
    end

    repeat (2) step();
    chk("final_busy",   64'(pm_busy),   64'd0);
    chk("final_rvalid", 64'(pm_rvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
